// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: hazard sources in, stall/flush/forward controls out.
interface hazard_ctrl_if #(
  parameter int NUM_RS = 2,
  parameter int PERF_W = 32
);
  logic [NUM_RS*5-1:0] if_id_rs;
  logic [NUM_RS*5-1:0] id_ex_rs;
  logic [4:0]          id_ex_rd;
  logic                id_ex_mem_read;
  logic                id_ex_reg_write;
  logic                id_ex_is_mdu;
  logic                ex_redirect;
  logic [4:0]          ex_mem_rd;
  logic                ex_mem_reg_write;
  logic [4:0]          mem_wb_rd;
  logic                mem_wb_reg_write;
  logic                dmem_req;
  logic                dmem_ready;

  logic [NUM_RS*2-1:0] forward;
  logic                pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic                if_id_flush, id_ex_flush, ex_mem_flush;
  logic                mdu_issue, mdu_done;
  logic [4:0]          mdu_busy_rd;
  logic [PERF_W-1:0]   perf_stall_cyc, perf_flush_cnt, perf_mdu_wait;

  modport master (
    output if_id_rs, id_ex_rs, id_ex_rd, id_ex_mem_read, id_ex_reg_write, id_ex_is_mdu,
           ex_redirect, ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write,
           dmem_req, dmem_ready,
    input  forward, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mdu_issue, mdu_done, mdu_busy_rd,
           perf_stall_cyc, perf_flush_cnt, perf_mdu_wait
  );

  modport slave (
    input  if_id_rs, id_ex_rs, id_ex_rd, id_ex_mem_read, id_ex_reg_write, id_ex_is_mdu,
           ex_redirect, ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write,
           dmem_req, dmem_ready,
    output forward, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mdu_issue, mdu_done, mdu_busy_rd,
           perf_stall_cyc, perf_flush_cnt, perf_mdu_wait
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller: per-operand forwarding, load-use, dmem wait, redirect, MDU scoreboard.
// Optional saturating perf counters enabled by defining HAZARD_PERF_EN.

// Per-operand compare slice: forwarding select plus load-use and MDU-dependency hits.
module hcu_fwd_lane (
  input  logic [4:0] id_rs,
  input  logic [4:0] ex_rs,
  input  logic [4:0] id_ex_rd,
  input  logic [4:0] ex_mem_rd,
  input  logic       ex_mem_reg_write,
  input  logic [4:0] mem_wb_rd,
  input  logic       mem_wb_reg_write,
  input  logic [4:0] busy_rd,
  output logic [1:0] fwd,
  output logic       lu_hit,
  output logic       mdu_hit
);
  always_comb begin
    fwd = 2'b00;
    if (ex_mem_reg_write && ex_mem_rd != 5'd0 && ex_mem_rd == ex_rs)
      fwd = 2'b10;
    else if (mem_wb_reg_write && mem_wb_rd != 5'd0 && mem_wb_rd == ex_rs)
      fwd = 2'b01;
    lu_hit  = (id_rs != 5'd0) && (id_rs == id_ex_rd);
    mdu_hit = (ex_rs != 5'd0) && (ex_rs == busy_rd);
  end
endmodule

module hazard_ctrl_unit #(
  parameter int NUM_RS  = 2,
  parameter int MDU_LAT = 4,
  parameter int PERF_W  = 32
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave hz
);
  localparam int CW = $clog2(MDU_LAT);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdu_state_e;

  mdu_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    busy_rd_q, busy_rd_d;

  logic [NUM_RS-1:0][1:0] fwd_w;
  logic [NUM_RS-1:0]      lu_hit, mdu_hit;

  for (genvar i = 0; i < NUM_RS; i++) begin : g_lane
    hcu_fwd_lane u_lane (
      .id_rs           (hz.if_id_rs[i*5 +: 5]),
      .ex_rs           (hz.id_ex_rs[i*5 +: 5]),
      .id_ex_rd        (hz.id_ex_rd),
      .ex_mem_rd       (hz.ex_mem_rd),
      .ex_mem_reg_write(hz.ex_mem_reg_write),
      .mem_wb_rd       (hz.mem_wb_rd),
      .mem_wb_reg_write(hz.mem_wb_reg_write),
      .busy_rd         (busy_rd_q),
      .fwd             (fwd_w[i]),
      .lu_hit          (lu_hit[i]),
      .mdu_hit         (mdu_hit[i])
    );
  end

  logic mem_wait, issue_w, done_w, mdu_hazard, load_use;
  logic row_redirect, row_mdu;
  logic pc_st, ifid_st, idex_st, exmem_st, ifid_fl, idex_fl, exmem_fl;

  always_comb begin
    mem_wait = hz.dmem_req & ~hz.dmem_ready;
    issue_w  = (state_q == IDLE) & hz.id_ex_is_mdu & ~mem_wait;
    done_w   = (state_q == BUSY) & (cnt_q == '0);

    mdu_hazard = (state_q == BUSY) &
                 ((|mdu_hit) |
                  (hz.id_ex_reg_write & (hz.id_ex_rd == busy_rd_q) & (busy_rd_q != 5'd0)) |
                  hz.id_ex_is_mdu);
    load_use   = hz.id_ex_mem_read & (hz.id_ex_rd != 5'd0) & (|lu_hit);

    pc_st = 1'b0; ifid_st = 1'b0; idex_st = 1'b0; exmem_st = 1'b0;
    ifid_fl = 1'b0; idex_fl = 1'b0; exmem_fl = 1'b0;
    row_redirect = 1'b0; row_mdu = 1'b0;
    // Only the highest-priority active row drives the controls; a redirect during a
    // memory wait is dropped because EX re-presents it once the freeze lifts.
    if (mem_wait) begin
      pc_st = 1'b1; ifid_st = 1'b1; idex_st = 1'b1; exmem_st = 1'b1;
    end else if (hz.ex_redirect) begin
      ifid_fl = 1'b1; idex_fl = 1'b1; row_redirect = 1'b1;
    end else if (mdu_hazard) begin
      pc_st = 1'b1; ifid_st = 1'b1; idex_st = 1'b1; exmem_fl = 1'b1; row_mdu = 1'b1;
    end else if (load_use) begin
      pc_st = 1'b1; ifid_st = 1'b1; idex_fl = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_rd_d = busy_rd_q;
    case (state_q)
      IDLE: if (issue_w) begin
        state_d   = BUSY;
        cnt_d     = CW'(MDU_LAT - 1);
        busy_rd_d = hz.id_ex_rd;
      end
      BUSY: if (done_w) begin
        state_d   = IDLE;
        busy_rd_d = 5'd0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_rd_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_rd_q <= busy_rd_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cyc_q, stall_cyc_d, flush_cnt_q, flush_cnt_d, mdu_wait_q, mdu_wait_d;

  always_comb begin
    stall_cyc_d = stall_cyc_q;
    flush_cnt_d = flush_cnt_q;
    mdu_wait_d  = mdu_wait_q;
    if (pc_st && !(&stall_cyc_q))        stall_cyc_d = stall_cyc_q + 1'b1;
    if (row_redirect && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
    if (row_mdu && !(&mdu_wait_q))       mdu_wait_d  = mdu_wait_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
      mdu_wait_q  <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      flush_cnt_q <= flush_cnt_d;
      mdu_wait_q  <= mdu_wait_d;
    end
  end

  always_comb begin
    hz.perf_stall_cyc = stall_cyc_q;
    hz.perf_flush_cnt = flush_cnt_q;
    hz.perf_mdu_wait  = mdu_wait_q;
  end
`else
  always_comb begin
    hz.perf_stall_cyc = '0;
    hz.perf_flush_cnt = '0;
    hz.perf_mdu_wait  = '0;
  end
`endif

  // Combinational outputs are forced quiet while reset is held.
  always_comb begin
    hz.forward      = rst_n ? fwd_w : '0;
    hz.pc_stall     = rst_n & pc_st;
    hz.if_id_stall  = rst_n & ifid_st;
    hz.id_ex_stall  = rst_n & idex_st;
    hz.ex_mem_stall = rst_n & exmem_st;
    hz.if_id_flush  = rst_n & ifid_fl;
    hz.id_ex_flush  = rst_n & idex_fl;
    hz.ex_mem_flush = rst_n & exmem_fl;
    hz.mdu_issue    = rst_n & issue_w;
    hz.mdu_done     = rst_n & done_w;
    hz.mdu_busy_rd  = rst_n ? busy_rd_q : 5'd0;
  end
endmodule
